arrow_sequencer: RTL

ARROW_SEQUENCER -- requirements
Module: arrow_sequencer

---
 rtl/dance_pkg.sv | 38 +++
 rtl/arrow_sequencer_chart_rom.sv | 24 ++
 rtl/arrow_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dance_pkg.sv
// rtl/dance_pkg.sv - shared encodings, state type and scoring limits for arrow_sequencer
package dance_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int ARR_UP    = 0;
  localparam int ARR_DOWN  = 1;
  localparam int ARR_LEFT  = 2;
  localparam int ARR_RIGHT = 3;
  localparam int ARR_EN    = 4;

  localparam int SCORE_W = 2;
  localparam int TOTAL_W = 12;
  localparam int COMBO_W = 8;
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = 12'd4095;
  localparam logic [COMBO_W-1:0] COMBO_MAX = 8'd255;
  localparam logic [15:0]        LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_GAP, ST_DONE} state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] dir;
  } slot_t;

  // Direction codes line up with arr bit indices, so dir selects the one-hot bit directly.
  function automatic logic [4:0] arrow_bits(input slot_t s);
    arrow_bits = 5'd0;
    if (s.valid) begin
      arrow_bits[ARR_EN] = 1'b1;
      arrow_bits[s.dir]  = 1'b1;
    end
  endfunction

endpackage

// File: rtl/arrow_sequencer_chart_rom.sv
// rtl/arrow_sequencer_chart_rom.sv - fixed 8-entry chart, repeated across the song
module chart_rom
  import dance_pkg::*;
(
  input  logic [2:0] idx_i,
  output slot_t      slot_o
);

  always_comb begin
    slot_o = '{valid: 1'b0, dir: DIR_UP};
    case (idx_i)
      3'd0: slot_o = '{valid: 1'b1, dir: DIR_UP};
      3'd1: slot_o = '{valid: 1'b1, dir: DIR_DOWN};
      3'd2: slot_o = '{valid: 1'b1, dir: DIR_LEFT};
      3'd3: slot_o = '{valid: 1'b1, dir: DIR_RIGHT};
      3'd4: slot_o = '{valid: 1'b0, dir: DIR_UP};
      3'd5: slot_o = '{valid: 1'b1, dir: DIR_RIGHT};
      3'd6: slot_o = '{valid: 1'b1, dir: DIR_LEFT};
      3'd7: slot_o = '{valid: 1'b1, dir: DIR_DOWN};
      default: slot_o = '{valid: 1'b0, dir: DIR_UP};
    endcase
  end

endmodule

// File: rtl/arrow_sequencer.sv
// rtl/arrow_sequencer.sv - arrow chart sequencer with hit scoring
// RANDOM_CHART_EN selects LFSR-generated slots instead of the chart ROM.
module arrow_sequencer
  import dance_pkg::*;
#(
  parameter int CHART_LEN = 32,
  parameter int HOLD_CYC  = 2,
  parameter int MIN_GAP   = 2
) (
  input  logic                 clk_arr,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 pause,
  input  logic [7:0]           tempo,
  input  logic                 update,
  input  logic [SCORE_W-1:0]   score,
  output logic [4:0]           arr,
  output logic                 busy,
  output logic                 done,
  output logic [TOTAL_W-1:0]   total,
  output logic [COMBO_W-1:0]   combo,
  output logic [COMBO_W-1:0]   max_combo
);

  localparam int IDX_W = (CHART_LEN > 1) ? $clog2(CHART_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(CHART_LEN - 1);
  localparam logic [3:0]       HOLD_LAST = 4'(HOLD_CYC - 1);
  localparam logic [7:0]       GAP_FLOOR = 8'(MIN_GAP);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   slot_q, slot_d;
  logic [3:0]         hold_q, hold_d;
  logic [7:0]         gap_q, gap_d;
  logic [7:0]         tempo_q, tempo_d;
  logic               upd_prev_q;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [COMBO_W-1:0] max_q, max_d;
  logic [TOTAL_W:0]   sum;
  logic               song_start, upd_edge, gap_last;
  slot_t              cur_slot;

  assign song_start = (state_q == ST_IDLE) && start;
  assign upd_edge   = update && !upd_prev_q;
  assign gap_last   = (state_q == ST_GAP) && !pause && (gap_q == tempo_q - 8'd1);

`ifdef RANDOM_CHART_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign cur_slot = '{valid: 1'b1, dir: lfsr_q[1:0]};

  always_comb begin
    lfsr_d = lfsr_q;
    if (song_start)                         lfsr_d = LFSR_SEED;
    else if (gap_last && slot_q != LAST_SLOT) lfsr_d = {lfsr_q[14:0], lfsr_fb};
  end

  always_ff @(posedge clk_arr) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end
`else
  chart_rom u_chart_rom (
    .idx_i  (3'(slot_q)),
    .slot_o (cur_slot)
  );
`endif

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    tempo_d = tempo_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_EMIT;
          slot_d  = '0;
          hold_d  = 4'd0;
          tempo_d = (tempo < GAP_FLOOR) ? GAP_FLOOR : tempo;
        end
      end
      ST_EMIT: begin
        busy = 1'b1;
        if (hold_q == HOLD_LAST) begin
          state_d = ST_GAP;
          gap_d   = 8'd0;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      ST_GAP: begin
        busy = 1'b1;
        if (gap_last) begin
          if (slot_q == LAST_SLOT) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_EMIT;
            slot_d  = slot_q + 1'b1;
            hold_d  = 4'd0;
          end
        end else if (!pause) begin
          gap_d = gap_q + 8'd1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign arr = (state_q == ST_EMIT) ? arrow_bits(cur_slot) : 5'd0;

  // A start accepted in IDLE clears scoring and swallows any coincident hit.
  always_comb begin
    total_d = total_q;
    combo_d = combo_q;
    max_d   = max_q;
    sum     = {1'b0, total_q} + (TOTAL_W + 1)'(score);
    if (song_start) begin
      total_d = '0;
      combo_d = '0;
      max_d   = '0;
    end else if (upd_edge) begin
      total_d = (sum > {1'b0, TOTAL_MAX}) ? TOTAL_MAX : sum[TOTAL_W-1:0];
      if (score != '0) combo_d = (combo_q == COMBO_MAX) ? combo_q : combo_q + 8'd1;
      else             combo_d = '0;
      if (combo_d > max_q) max_d = combo_d;
    end
  end

  always_ff @(posedge clk_arr) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      hold_q     <= 4'd0;
      gap_q      <= 8'd0;
      tempo_q    <= 8'd0;
      upd_prev_q <= 1'b0;
      total_q    <= '0;
      combo_q    <= '0;
      max_q      <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      hold_q     <= hold_d;
      gap_q      <= gap_d;
      tempo_q    <= tempo_d;
      upd_prev_q <= update;
      total_q    <= total_d;
      combo_q    <= combo_d;
      max_q      <= max_d;
    end
  end

  assign total     = total_q;
  assign combo     = combo_q;
  assign max_combo = max_q;

endmodule
